// File: rtl/dram_sched_buffer_pkg.sv
// Shared types for the DRAM request buffer: address layout, queue entry and scheduler states.
package dram_pack;

   localparam int DRAM_DATA_W = 32;
   localparam int T_REFI_CYC  = 6240;

   typedef struct packed {
      logic        rank;
      logic        rsvd;
      logic [14:0] row;
      logic [1:0]  bank;
      logic        bg1;
      logic [6:0]  col_1;
      logic        bg0;
      logic [2:0]  col_0;
      logic [1:0]  byte_off;
   } addr_x4_t;

   localparam int DRAM_ADDR_W = $bits(addr_x4_t);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      REF_WAIT = 2'd1,
      REF      = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic                   wen;
      addr_x4_t               addr;
      logic [DRAM_DATA_W-1:0] wdata;
   } sched_entry_t;

endpackage

// File: rtl/dram_sched_buffer_if.sv
// Host-side request/response bundle of the DRAM request buffer.
interface dram_sched_buffer_if #(
   parameter int ADDR_W = 33,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_wen;
   logic [DATA_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_wen, resp_rdata
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata,
      output req_ready, resp_valid, resp_wen, resp_rdata
   );
endinterface

// File: rtl/dram_sched_buffer_req_fifo.sv
// In-order request queue; exposes the head entry and the one behind it.
module dram_req_fifo
   import dram_pack::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   push,
   input  logic                   pop,
   input  sched_entry_t           push_entry,
   output sched_entry_t           head,
   output sched_entry_t           next,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);

   sched_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] nxt_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count == (PTR_W+1)'(DEPTH);
   assign empty   = count == '0;
   // A full queue refuses the push even when the head leaves in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign nxt_ptr = rd_ptr + 1'b1;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];
   assign next = mem[nxt_ptr];
endmodule

// File: rtl/dram_sched_buffer.sv
// Request buffer/scheduler in front of the DRAM command generator: queue, address decode,
// tREFI refresh timer with postponement debt, and host response register.
//  state    | meaning
//  RUN      | normal service of queued requests
//  REF_WAIT | refresh owed, finishing the outstanding head request first
//  REF      | REFRESH raised, request fields masked until the generator finishes
module dram_sched_buffer
   import dram_pack::*;
#(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = DRAM_ADDR_W,
   parameter int DATA_W   = DRAM_DATA_W,
   parameter int T_REFI   = T_REFI_CYC,
   parameter int MAX_DEBT = 8
) (
   input  logic                 CLK,
   input  logic                 nRST,
   dram_sched_buffer_if.slave   host,
   output logic [2:0]           Ra0,
   output logic [2:0]           Ra1,
   output logic [1:0]           BG0,
   output logic [1:0]           BG1,
   output logic [1:0]           BA0,
   output logic [1:0]           BA1,
   output logic [17:0]          R0,
   output logic [17:0]          R1,
   output logic [9:0]           COL0,
   output logic [9:0]           COL1,
   output logic                 ramREN_curr,
   output logic                 ramWEN_curr,
   output logic                 ramREN_ftrt,
   output logic                 ramWEN_ftrt,
   output logic [DATA_W-1:0]    write_data,
   output logic                 REFRESH,
   input  logic                 request_done,
   input  logic [DATA_W-1:0]    data_callback
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int TMR_W  = $clog2(T_REFI);
   localparam int DEBT_W = $clog2(MAX_DEBT + 1);

   sched_state_t      state, state_nx;
   sched_entry_t      push_entry, fifo_head, fifo_next, head_e, next_e;
   logic [ADDR_W-1:0] req_addr;
   logic [CNT_W-1:0]  count;
   logic              full, empty, push, pop, head_vld, next_vld, ref_done, wrap;
   logic [TMR_W-1:0]  timer;
   logic [DEBT_W-1:0] debt, debt_nx;

   assign req_addr       = host.req_addr;
   assign host.req_ready = !full;
   assign push           = host.req_valid && !full;
   assign push_entry     = '{wen: host.req_wen, addr: addr_x4_t'(req_addr), wdata: host.req_wdata};

   dram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK        (CLK),
      .nRST       (nRST),
      .push       (push),
      .pop        (pop),
      .push_entry (push_entry),
      .head       (fifo_head),
      .next       (fifo_next),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_nx;
   end

   // Any owed refresh is taken at the next request boundary, so saturated debt needs no special case.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:      if (debt != '0) state_nx = empty ? REF : REF_WAIT;
         REF_WAIT: if (request_done || empty) state_nx = REF;
         REF:      if (request_done) state_nx = RUN;
         default:  state_nx = RUN;
      endcase
   end

   always_comb begin
      REFRESH  = 1'b0;
      head_vld = 1'b0;
      next_vld = 1'b0;
      pop      = 1'b0;
      ref_done = 1'b0;
      case (state)
         RUN, REF_WAIT: begin
            head_vld = !empty;
            next_vld = count >= CNT_W'(2);
            pop      = request_done && !empty;
         end
         REF: begin
            REFRESH  = 1'b1;
            ref_done = request_done;
         end
         default: ;
      endcase
   end

   assign wrap = timer == TMR_W'(T_REFI - 1);

   always_comb begin
      debt_nx = debt;
      if (ref_done && debt != '0)                debt_nx = debt_nx - 1'b1;
      if (wrap && debt_nx != DEBT_W'(MAX_DEBT)) debt_nx = debt_nx + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         timer <= '0;
         debt  <= '0;
      end else begin
         timer <= wrap ? '0 : timer + 1'b1;
         debt  <= debt_nx;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         host.resp_valid <= 1'b0;
         host.resp_wen   <= 1'b0;
         host.resp_rdata <= '0;
      end else begin
         host.resp_valid <= pop;
         host.resp_wen   <= pop && fifo_head.wen;
         host.resp_rdata <= (pop && !fifo_head.wen) ? data_callback : '0;
      end
   end

   assign head_e = head_vld ? fifo_head : '0;
   assign next_e = next_vld ? fifo_next : '0;

   assign Ra0         = {2'b00, head_e.addr.rank};
   assign BG0         = {head_e.addr.bg1, head_e.addr.bg0};
   assign BA0         = head_e.addr.bank;
   assign R0          = {3'b000, head_e.addr.row};
   assign COL0        = {head_e.addr.col_1, head_e.addr.col_0};
   assign ramREN_curr = head_vld && !head_e.wen;
   assign ramWEN_curr = head_e.wen;
   assign write_data  = head_e.wdata;

   assign Ra1         = {2'b00, next_e.addr.rank};
   assign BG1         = {next_e.addr.bg1, next_e.addr.bg0};
   assign BA1         = next_e.addr.bank;
   assign R1          = {3'b000, next_e.addr.row};
   assign COL1        = {next_e.addr.col_1, next_e.addr.col_0};
   assign ramREN_ftrt = next_vld && !next_e.wen;
   assign ramWEN_ftrt = next_e.wen;

   wire unused_fields = ^{head_e.addr.rsvd, head_e.addr.byte_off,
                          next_e.addr.rsvd, next_e.addr.byte_off, next_e.wdata};
endmodule

// File: tb/tb_dram_sched_buffer.sv
// Directed bench for dram_sched_buffer with a response scoreboard; tREFI shortened to 16.
module tb_dram_sched_buffer;
   localparam int T_REFI = 16;

   typedef struct packed {
      logic        wen;
      logic [31:0] rdata;
   } resp_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [2:0]  Ra0, Ra1;
   logic [1:0]  BG0, BG1, BA0, BA1;
   logic [17:0] R0, R1;
   logic [9:0]  COL0, COL1;
   logic        ramREN_curr, ramWEN_curr, ramREN_ftrt, ramWEN_ftrt, REFRESH;
   logic [31:0] write_data;
   logic        request_done;
   logic [31:0] data_callback;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc   = 0;
   resp_t exp_q[$];
   bit    wen_q[$];

   always #5 CLK = ~CLK;

   dram_sched_buffer_if #(.ADDR_W(33), .DATA_W(32)) bus ();

   dram_sched_buffer #(
      .DEPTH(8), .ADDR_W(33), .DATA_W(32), .T_REFI(T_REFI), .MAX_DEBT(8)
   ) dut (
      .CLK(CLK), .nRST(nRST), .host(bus),
      .Ra0(Ra0), .Ra1(Ra1), .BG0(BG0), .BG1(BG1), .BA0(BA0), .BA1(BA1),
      .R0(R0), .R1(R1), .COL0(COL0), .COL1(COL1),
      .ramREN_curr(ramREN_curr), .ramWEN_curr(ramWEN_curr),
      .ramREN_ftrt(ramREN_ftrt), .ramWEN_ftrt(ramWEN_ftrt),
      .write_data(write_data), .REFRESH(REFRESH),
      .request_done(request_done), .data_callback(data_callback)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then check any response against the scoreboard.
   task automatic step();
      resp_t r;
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.resp_valid === 1'b1) begin
         chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("resp_wen", bus.resp_wen, r.wen);
            chk("resp_rdata", bus.resp_rdata, r.rdata);
         end
      end
   endtask

   task automatic drive(input bit pv, input bit pw, input logic [32:0] pa, input logic [31:0] pd,
                        input bit dv, input bit pop_exp, input logic [31:0] dcb);
      resp_t r;
      bus.req_valid = pv;
      bus.req_wen   = pw;
      bus.req_addr  = pa;
      bus.req_wdata = pd;
      request_done  = dv;
      data_callback = dcb;
      if (dv && pop_exp && wen_q.size() > 0) begin
         r.wen   = wen_q.pop_front();
         r.rdata = r.wen ? 32'd0 : dcb;
         exp_q.push_back(r);
      end
      if (pv && bus.req_ready) wen_q.push_back(pw);
      step();
      bus.req_valid = 1'b0;
      bus.req_wen   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      request_done  = 1'b0;
      data_callback = '0;
   endtask

   task automatic pulse_reset();
      #2;
      nRST = 1'b0;
      #1;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_wen_curr", ramWEN_curr, 1'b0);
      chk("rst_ren_curr", ramREN_curr, 1'b0);
      chk("rst_refresh", REFRESH, 1'b0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      exp_q.delete();
      wen_q.delete();
      step();
      nRST = 1'b1;
      cyc  = 0;
   endtask

   function automatic logic [32:0] mk_addr(input logic rank, input logic [14:0] row, input logic [1:0] bank,
                                           input logic bg1, input logic [6:0] col1, input logic bg0,
                                           input logic [2:0] col0);
      return {rank, 1'b0, row, bank, bg1, col1, bg0, col0, 2'b00};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32:0] a;
      bus.req_valid = 1'b0;
      bus.req_wen   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      request_done  = 1'b0;
      data_callback = '0;

      // Reset values
      #3;
      chk("reset_req_ready", bus.req_ready, 1'b1);
      chk("reset_R0", R0, 18'd0);
      chk("reset_COL1", COL1, 10'd0);
      chk("reset_write_data", write_data, 32'd0);
      chk("reset_refresh", REFRESH, 1'b0);
      chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
      step();
      nRST = 1'b1;
      cyc  = 0;

      // Asynchronous clear of a non-empty queue
      drive(1, 1, 33'h0, 32'h1, 0, 0, 0);
      chk("t1_wen_curr", ramWEN_curr, 1'b1);
      pulse_reset();

      // Decode, with ignored bits [31] and [1:0] set
      a = mk_addr(1'b1, 15'h1ABC, 2'd2, 1'b1, 7'h55, 1'b0, 3'd5) | (33'd1 << 31) | 33'd3;
      drive(1, 0, a, 32'h0, 0, 0, 0);
      chk("t2_Ra0", Ra0, 3'd1);
      chk("t2_R0", R0, 18'h01ABC);
      chk("t2_BA0", BA0, 2'd2);
      chk("t2_BG0", BG0, 2'b10);
      chk("t2_COL0", COL0, 10'h2AD);
      chk("t2_ren_curr", ramREN_curr, 1'b1);
      chk("t2_Ra1_invalid", Ra1, 3'd0);
      drive(1, 1, mk_addr(1'b0, 15'h7FFF, 2'd1, 1'b0, 7'h7F, 1'b1, 3'd7), 32'hA5A5_0001, 0, 0, 0);
      chk("t2_R1", R1, 18'h07FFF);
      chk("t2_BA1", BA1, 2'd1);
      chk("t2_BG1", BG1, 2'b01);
      chk("t2_COL1", COL1, 10'h3FF);
      chk("t2_wen_ftrt", ramWEN_ftrt, 1'b1);
      drive(0, 0, 0, 0, 1, 1, 32'h1234_5678);
      chk("t2_R0_after_pop", R0, 18'h07FFF);
      chk("t2_write_data", write_data, 32'hA5A5_0001);
      chk("t2_wen_ftrt_empty", ramWEN_ftrt, 1'b0);
      drive(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
      chk("t2_drained", ramWEN_curr, 1'b0);
      pulse_reset();

      // Fill, full-blocks-push-on-pop, push+pop keeps count
      for (int i = 0; i < 8; i++)
         drive(1, 1, mk_addr(1'b0, 15'(i + 1), 2'd0, 1'b0, 7'd0, 1'b0, 3'd0), 32'h100 + 32'(i + 1), 0, 0, 0);
      chk("t3_full_ready", bus.req_ready, 1'b0);
      chk("t3_R0", R0, 18'd1);
      chk("t3_R1", R1, 18'd2);
      drive(1, 1, mk_addr(1'b0, 15'd9, 2'd0, 1'b0, 7'd0, 1'b0, 3'd0), 32'h109, 1, 1, 32'hFFFF_FFFF);
      chk("t3_ready_after_pop", bus.req_ready, 1'b1);
      chk("t3_R0_entry2", R0, 18'd2);
      chk("t3_R1_entry3", R1, 18'd3);
      chk("t3_write_data", write_data, 32'h102);
      drive(1, 1, mk_addr(1'b0, 15'd10, 2'd0, 1'b0, 7'd0, 1'b0, 3'd0), 32'h10A, 1, 1, 32'h0);
      chk("t3_pushpop_ready", bus.req_ready, 1'b1);
      chk("t3_pushpop_R0", R0, 18'd3);
      drive(1, 1, mk_addr(1'b0, 15'd11, 2'd0, 1'b0, 7'd0, 1'b0, 3'd0), 32'h10B, 0, 0, 0);
      chk("t3_refull_ready", bus.req_ready, 1'b0);
      pulse_reset();

      // Refresh with an empty queue
      for (int i = 0; i < 40 && REFRESH !== 1'b1; i++) step();
      chk("t4_refresh_seen", REFRESH, 1'b1);
      chk("t4_refresh_cycle", 64'(cyc), 64'(T_REFI + 1));
      drive(0, 0, 0, 0, 1, 0, 32'h77);
      chk("t4_refresh_cleared", REFRESH, 1'b0);
      chk("t4_no_resp", bus.resp_valid, 1'b0);
      step();
      step();
      chk("t4_debt_cleared", REFRESH, 1'b0);
      pulse_reset();

      // Refresh postponed behind an outstanding read
      drive(1, 0, mk_addr(1'b0, 15'h0042, 2'd3, 1'b0, 7'd1, 1'b0, 3'd1), 32'h0, 0, 0, 0);
      drive(1, 1, mk_addr(1'b1, 15'h0043, 2'd0, 1'b0, 7'd2, 1'b0, 3'd2), 32'h5555_AAAA, 0, 0, 0);
      for (int i = 0; i < 40 && cyc < T_REFI + 4; i++) step();
      chk("t5_refresh_held", REFRESH, 1'b0);
      chk("t5_ren_curr", ramREN_curr, 1'b1);
      chk("t5_wen_ftrt", ramWEN_ftrt, 1'b1);
      drive(0, 0, 0, 0, 1, 1, 32'h0000_CAFE);
      chk("t5_refresh_now", REFRESH, 1'b1);
      chk("t5_curr_masked", ramWEN_curr, 1'b0);
      chk("t5_R0_masked", R0, 18'd0);
      chk("t5_ftrt_masked", ramWEN_ftrt, 1'b0);
      drive(0, 0, 0, 0, 1, 0, 32'h0);
      chk("t5_refresh_done", REFRESH, 1'b0);
      chk("t5_head_back", ramWEN_curr, 1'b1);
      chk("t5_Ra0", Ra0, 3'd1);
      drive(0, 0, 0, 0, 1, 1, 32'hBEEF);
      pulse_reset();

      // Reset mid-operation drops entries
      for (int i = 0; i < 3; i++)
         drive(1, 1, mk_addr(1'b0, 15'(i), 2'd0, 1'b0, 7'd0, 1'b0, 3'd0), 32'(i), 0, 0, 0);
      chk("t6_wen_ftrt_before", ramWEN_ftrt, 1'b1);
      pulse_reset();
      drive(0, 0, 0, 0, 1, 0, 32'h55);
      chk("t6_no_resp", bus.resp_valid, 1'b0);
      chk("t6_ready", bus.req_ready, 1'b1);
      chk("t6_wen_curr", ramWEN_curr, 1'b0);
      drive(1, 0, mk_addr(1'b0, 15'h0123, 2'd1, 1'b1, 7'd0, 1'b0, 3'd0), 32'h0, 0, 0, 0);
      chk("t6_single_head", ramREN_curr, 1'b1);
      chk("t6_no_next", ramREN_ftrt, 1'b0);
      chk("t6_R0", R0, 18'h00123);
      drive(0, 0, 0, 0, 1, 1, 32'h600D_F00D);
      step();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
